vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters: H_VISIBLE 640, H_FP 16, H_SYNC 96, H_BP 48, V_VISIBLE 480, V_FP 10, V_SYNC 2, V_BP 33; H_TOTAL = sum of the H parameters (800), V_TOTAL = sum of the V parameters (525).
REQ-002 SHALL have port vga_clk, input, 1, pixel clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port en, input, 1, advance enable; low freezes all state and outputs.
REQ-005 SHALL have port DrawX, output, 10, current pixel column 0..H_TOTAL-1.
REQ-006 SHALL have port DrawY, output, 10, current line 0..V_TOTAL-1.
REQ-007 SHALL have port blank, output, 1, high inside the visible region; the pixel pipeline draws only when blank is high.
REQ-008 SHALL have port hs, output, 1, horizontal sync, active-low.
REQ-009 SHALL have port vs, output, 1, vertical sync, active-low.
REQ-010 SHALL have port line_start, output, 1, one-cycle pulse while DrawX==0.
REQ-011 SHALL have port frame_start, output, 1, one-cycle pulse while DrawX==0 and DrawY==0.
REQ-012 SHALL have port frame_cnt, output, 8, count of frames started since reset; drives sprite animation.

Function
REQ-013 SHALL register every output; no output is combinationally derived from another port.
REQ-014 SHALL keep all outputs in the same cycle consistent with a single (DrawX, DrawY) position, with zero skew between the position and its decoded flags.
REQ-015 SHALL advance DrawX by 1 on each rising edge with en=1; at H_TOTAL-1 it wraps to 0.
REQ-016 SHALL advance DrawY by 1 only when DrawX wraps; at V_TOTAL-1 it wraps to 0 on the same edge that DrawX wraps.
REQ-017 SHALL assert blank iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-018 SHALL drive hs=0 iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (656..751).
REQ-019 SHALL drive vs=0 iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (490..491), for every DrawX on those lines.
REQ-020 SHALL raise line_start for exactly one enabled cycle per line, and frame_start for exactly one enabled cycle per frame.
REQ-021 SHALL increment frame_cnt (mod 256, 255 wraps to 0) on the same edge that presents frame_start=1; the first frame after reset presents frame_cnt=1.
REQ-022 SHALL, when en=0, hold every output including the pulses at its current value; a held pulse does not re-increment frame_cnt.
REQ-023 SHALL resume from the frozen position on the first enabled edge, with no skipped or repeated position.
REQ-024 SHALL present position (0,0) on the first enabled edge after reset release: blank=1, hs=1, vs=1, line_start=1, frame_start=1.
REQ-025 SHALL treat simultaneous DrawX and DrawY wrap as a frame wrap: the next position is (0,0) and frame_start asserts.
REQ-026 SHALL size counter arithmetic so that no intermediate value exceeds 10 bits with the default parameters.

Reset
REQ-027 SHALL, while reset_n=0, drive DrawX=0, DrawY=0, blank=0, hs=1, vs=1, line_start=0, frame_start=0, frame_cnt=0, independent of vga_clk.
REQ-028 SHALL, when reset_n asserts mid-frame, return all outputs to their REQ-027 values immediately and restart per REQ-024 after release.

Verification
REQ-029 Bench SHALL release reset with en=1 and step 1 edge -> DrawX=0, DrawY=0, blank=1, frame_start=1, frame_cnt=1; step 640 more edges -> DrawX=640, blank=0.
REQ-030 Bench SHALL run one full line -> hs=0 for exactly 96 consecutive cycles starting at DrawX=656; line_start period=800 cycles.
REQ-031 Bench SHALL run two full frames -> frame_start period=420000 cycles; vs=0 for exactly 1600 cycles starting at (0,490); DrawY max=524.
REQ-032 Bench SHALL hold en=0 for 50 cycles at DrawX=799, DrawY=524 -> outputs constant; next enabled edge -> (0,0), frame_start=1, frame_cnt +1 exactly once.
REQ-033 Bench SHALL assert reset_n=0 asynchronously at (300,200) -> outputs reach REQ-027 values before the next vga_clk edge; frame_cnt=0.
REQ-034 Bench SHALL force 256 frame starts -> frame_cnt wraps 255 to 0 on the frame_start edge.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_timing_gen : VGA raster position counter with registered sync/blank.   |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] c_h_last  = 10'(H_TOTAL - 1);
  localparam logic [9:0] c_v_last  = 10'(V_TOTAL - 1);
  localparam logic [9:0] c_h_vis   = 10'(H_VISIBLE);
  localparam logic [9:0] c_v_vis   = 10'(V_VISIBLE);
  localparam logic [9:0] c_hs_lo   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] c_hs_hi   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] c_vs_lo   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] c_vs_hi   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic       running_q, running_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       blank_q, blank_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [9:0] x_nxt, y_nxt;

  // Until the first enabled edge after reset the "next" position is (0,0),
  // so that edge presents the origin rather than stepping past it.
  always_comb begin
    x_nxt = 10'd0;
    y_nxt = 10'd0;
    if (running_q) begin
      if (x_q == c_h_last) begin
        x_nxt = 10'd0;
        y_nxt = (y_q == c_v_last) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_nxt = x_q + 10'd1;
        y_nxt = y_q;
      end
    end
  end

  // Flags are decoded from the next position and registered with it.
  always_comb begin
    running_d     = running_q;
    x_d           = x_q;
    y_d           = y_q;
    blank_d       = blank_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    frame_cnt_d   = frame_cnt_q;
    if (en) begin
      running_d     = 1'b1;
      x_d           = x_nxt;
      y_d           = y_nxt;
      blank_d       = (x_nxt < c_h_vis) && (y_nxt < c_v_vis);
      hs_d          = !((x_nxt >= c_hs_lo) && (x_nxt < c_hs_hi));
      vs_d          = !((y_nxt >= c_vs_lo) && (y_nxt < c_vs_hi));
      line_start_d  = (x_nxt == 10'd0);
      frame_start_d = (x_nxt == 10'd0) && (y_nxt == 10'd0);
      frame_cnt_d   = frame_start_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      running_q     <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      blank_q       <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      running_q     <= running_d;
      x_q           <= x_d;
      y_q           <= y_d;
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire
